pkt_serializer: RTL

//  Parametrised packet serializer: frames NUM_BYTES payload bytes as 9-bit symbols {k, byte[7:0]}.

---
 rtl/pkt_serializer.sv | 126 ++++++++++++
 1 files changed

// File: rtl/pkt_serializer.sv
// Packet serializer: frames a buffered NUM_BYTES packet as 9-bit {k, byte} symbols
// (SOP comma, payload, optional EOP) and shifts them out MSB first, idle commas between frames.
module pkt_serializer #(
  parameter int unsigned NUM_BYTES = 3,
  parameter logic [7:0]  COMMA     = 8'h3C,
  parameter bit          EOP_EN    = 1'b0,
  parameter logic [7:0]  EOP_CODE  = 8'hBC
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               valid_i,
  output logic                               ready_o,
  input  logic [8*NUM_BYTES-1:0]             data_i,
  output logic                               data_o,
  output logic                               sym_start_o,
  output logic                               k_o,
  output logic [$clog2(NUM_BYTES+1)-1:0]     byte_cnt_o,
  output logic                               busy_o,
  output logic                               done_o
);

  localparam int unsigned    BCW  = $clog2(NUM_BYTES + 1);
  localparam logic [BCW-1:0] LAST = BCW'(NUM_BYTES - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SOP  = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_EOP  = 2'd3;

  logic [1:0]             state_q, state_d;
  logic [8:0]             shreg_q;
  logic                   k_q;
  logic [3:0]             bit_cnt_q;
  logic                   pend_q;
  logic [8*NUM_BYTES-1:0] buf_q;
  logic [BCW-1:0]         byte_cnt_q, byte_cnt_d;
  logic                   done_q;

  logic       boundary;
  logic [8:0] sym_nxt;
  logic       load_data;
  logic       pend_clr;
  logic       frame_end;

  assign boundary = (bit_cnt_q == 4'd8);

  always_comb begin
    state_d    = state_q;
    sym_nxt    = {1'b1, COMMA};
    byte_cnt_d = '0;
    load_data  = 1'b0;
    frame_end  = 1'b0;
    case (state_q)
      ST_IDLE: if (pend_q) state_d = ST_SOP;
      ST_SOP: begin
        load_data = 1'b1;
        sym_nxt   = {1'b0, buf_q[7:0]};
        state_d   = ST_DATA;
      end
      ST_DATA: begin
        if (byte_cnt_q != LAST) begin
          load_data  = 1'b1;
          sym_nxt    = {1'b0, buf_q[7:0]};
          byte_cnt_d = byte_cnt_q + 1'b1;
        end else if (EOP_EN) begin
          sym_nxt = {1'b1, EOP_CODE};
          state_d = ST_EOP;
        end else begin
          // Without EOP a comma always separates frames, even if a packet is waiting.
          frame_end = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      ST_EOP: begin
        frame_end = 1'b1;
        state_d   = pend_q ? ST_SOP : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Buffer is released as soon as the last payload byte has been taken.
    pend_clr = load_data && (byte_cnt_d == LAST);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      shreg_q    <= {1'b1, COMMA};
      k_q        <= 1'b1;
      bit_cnt_q  <= 4'd0;
      pend_q     <= 1'b0;
      buf_q      <= '0;
      byte_cnt_q <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (boundary) begin
        bit_cnt_q  <= 4'd0;
        shreg_q    <= sym_nxt;
        k_q        <= sym_nxt[8];
        state_q    <= state_d;
        byte_cnt_q <= byte_cnt_d;
        done_q     <= frame_end;
      end else begin
        bit_cnt_q <= bit_cnt_q + 4'd1;
        shreg_q   <= {shreg_q[7:0], 1'b0};
      end
      // The buffer shifts down one byte per load so buf_q[7:0] is always the next byte.
      if (valid_i && ready_o) begin
        buf_q  <= data_i;
        pend_q <= 1'b1;
      end else if (boundary && load_data) begin
        buf_q <= buf_q >> 8;
        if (pend_clr) pend_q <= 1'b0;
      end
    end
  end

  assign ready_o     = !pend_q;
  assign data_o      = shreg_q[8];
  assign sym_start_o = (bit_cnt_q == 4'd0);
  assign k_o         = k_q;
  assign byte_cnt_o  = (state_q == ST_DATA) ? byte_cnt_q : '0;
  assign busy_o      = (state_q != ST_IDLE);
  assign done_o      = done_q;

endmodule
